instruction_fetch: RTL and testbench

Instruction fetch stage of the single-issue core. It holds the program counter, fetches 32-bit instruction words from instruction memory over a ready-gated request interface, and presents one instruction at a time to the decode/control stage. It computes the next PC from jump, jump-register and taken-branch inputs returned by downstream once the held instruction is accepted.

---
 rtl/instruction_fetch.sv | 155 +++++++++++++++
 tb/tb_instruction_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: holds the PC, fetches one 32-bit word at a time over a
// ready-gated request interface, presents it to decode and computes the next PC from
// jump / jump-register / taken-branch inputs when the held instruction retires.
// Optional feature macro: FETCH_ALIGN_CHECK_EN (misaligned redirects trap to a sticky
// FAULT state instead of being silently word-aligned).
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ins,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic        branch_taken,
    input  logic [31:0] rs_data,
    output logic [31:0] retired,
    output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
    typedef enum logic [1:0] {StIdle, StReq, StHold, StFault} state_e;
`else
    typedef enum logic [1:0] {StIdle, StReq, StHold} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] pc_inc;
    logic [31:0] target;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fault_q, fault_d;
`endif

    assign pc_inc    = pc_q + 32'd4;
    assign imem_req  = (state_q == StReq);
    assign imem_addr = pc_q;
    assign ins       = ins_q;
    assign ins_valid = (state_q == StHold);
    assign pc_out    = pc_q;
    assign pc_plus4  = pc_inc;
    assign retired   = retired_q;
`ifdef FETCH_ALIGN_CHECK_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

    // Redirect target selection; only consumed in the retire cycle.
    always_comb begin
        target = pc_inc;
        if (jump_reg) begin
            target = rs_data;
        end else if (jump) begin
            target = {pc_inc[31:28], ins_q[25:0], 2'b00};
        end else if (branch_taken) begin
            target = pc_inc + {{14{ins_q[15]}}, ins_q[15:0], 2'b00};
        end
    end

    // Next-state and datapath update for the fetch FSM.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        retired_d = retired_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fault_d   = fault_q;
`endif
        case (state_q)
            StIdle: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (RESET_PC[1:0] != 2'b00) begin
                    state_d = StFault;
                    fault_d = 1'b1;
                end else begin
                    state_d = StReq;
                end
`else
                state_d = StReq;
`endif
            end
            StReq: begin
                if (imem_ready) begin
                    ins_d   = imem_rdata;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (ins_ready) begin
                    retired_d = retired_q + 32'd1;
`ifdef FETCH_ALIGN_CHECK_EN
                    // A misaligned target never reaches the PC; the core stops here.
                    if (target[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = StFault;
                    end else begin
                        pc_d    = target;
                        state_d = StReq;
                    end
`else
                    pc_d    = target & 32'hFFFF_FFFC;
                    state_d = StReq;
`endif
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            StFault: begin
                state_d = StFault;
            end
`endif
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // PC, held instruction, retire counter and fault flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= RESET_PC;
            ins_q     <= 32'h0;
            retired_q <= 32'h0;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= 1'b0;
`endif
        end else begin
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            retired_q <= retired_d;
`ifdef FETCH_ALIGN_CHECK_EN
            fault_q   <= fault_d;
`endif
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch (RESET_PC = 0).
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] ins;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        jump;
    logic        jump_reg;
    logic        branch_taken;
    logic [31:0] rs_data;
    logic [31:0] retired;
    logic        fetch_fault;

    int unsigned n_tests;
    int unsigned n_fail;
    logic [31:0] exp_ret;

    instruction_fetch #(
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .ins         (ins),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .jump        (jump),
        .jump_reg    (jump_reg),
        .branch_taken(branch_taken),
        .rs_data     (rs_data),
        .retired     (retired),
        .fetch_fault (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d)", n_tests);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // In REQ: return one word from memory, then confirm it is held.
    task automatic fetch(input logic [31:0] word);
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        check_eq("fetch_valid", {31'd0, ins_valid}, 32'd1);
        check_eq("fetch_ins", ins, word);
    endtask

    // In HOLD: accept the instruction with the given redirect inputs.
    task automatic accept(input logic jr, input logic j, input logic br, input logic [31:0] rs);
        ins_ready    = 1'b1;
        jump_reg     = jr;
        jump         = j;
        branch_taken = br;
        rs_data      = rs;
        step();
        ins_ready    = 1'b0;
        jump_reg     = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        rs_data      = 32'h0;
        exp_ret      = exp_ret + 32'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        exp_ret = 32'd0;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        exp_ret      = 32'd0;
        reset        = 1'b1;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        ins_ready    = 1'b0;
        jump         = 1'b0;
        jump_reg     = 1'b0;
        branch_taken = 1'b0;
        rs_data      = 32'h0;

        // Reset state.
        step();
        step();
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_valid", {31'd0, ins_valid}, 32'd0);
        check_eq("rst_ins", ins, 32'h0);
        check_eq("rst_pc", pc_out, 32'h0);
        check_eq("rst_retired", retired, 32'h0);
        check_eq("rst_fault", {31'd0, fetch_fault}, 32'd0);
        reset = 1'b0;
        check_eq("idle_req", {31'd0, imem_req}, 32'd0);
        step();
        check_eq("first_req", {31'd0, imem_req}, 32'd1);

        // Sequential fetch with both handshakes always ready.
        imem_ready = 1'b1;
        imem_rdata = 32'h0;
        ins_ready  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_eq("seq_addr", imem_addr, 32'(4 * i));
            check_eq("seq_req", {31'd0, imem_req}, 32'd1);
            step();
            check_eq("seq_valid", {31'd0, ins_valid}, 32'd1);
            check_eq("seq_pc", pc_out, 32'(4 * i));
            check_eq("seq_pc4", pc_plus4, 32'(4 * i + 4));
            step();
            exp_ret = exp_ret + 32'd1;
        end
        imem_ready = 1'b0;
        ins_ready  = 1'b0;
        check_eq("seq_addr3", imem_addr, 32'h0000_000C);
        check_eq("seq_retired", retired, 32'd3);

        // Memory stall for 5 cycles; address must hold.
        for (int i = 0; i < 5; i++) begin
            step();
            check_eq("mstall_req", {31'd0, imem_req}, 32'd1);
            check_eq("mstall_addr", imem_addr, 32'h0000_000C);
            check_eq("mstall_valid", {31'd0, ins_valid}, 32'd0);
        end
        fetch(32'h1234_5678);

        // Downstream stall for 4 cycles; everything held, no new request.
        for (int i = 0; i < 4; i++) begin
            step();
            check_eq("dstall_ins", ins, 32'h1234_5678);
            check_eq("dstall_pc", pc_out, 32'h0000_000C);
            check_eq("dstall_req", {31'd0, imem_req}, 32'd0);
            check_eq("dstall_valid", {31'd0, ins_valid}, 32'd1);
        end
        accept(1'b1, 1'b0, 1'b0, 32'h0000_0100);
        check_eq("jr_addr", imem_addr, 32'h0000_0100);
        check_eq("jr_retired", retired, exp_ret);

        // Jump at 0x100 with ins 0x0C000010 -> 0x40.
        fetch(32'h0C00_0010);
        check_eq("j_pc", pc_out, 32'h0000_0100);
        accept(1'b0, 1'b1, 1'b0, 32'h0);
        check_eq("j_addr", imem_addr, 32'h0000_0040);

        // Redirects and ins_ready outside HOLD do nothing.
        jump_reg  = 1'b1;
        rs_data   = 32'h0000_0800;
        ins_ready = 1'b1;
        step();
        step();
        jump_reg  = 1'b0;
        rs_data   = 32'h0;
        ins_ready = 1'b0;
        check_eq("ign_addr", imem_addr, 32'h0000_0040);
        check_eq("ign_req", {31'd0, imem_req}, 32'd1);
        check_eq("ign_retired", retired, exp_ret);

        // Priority: jump_reg beats jump and branch.
        fetch(32'h0);
        accept(1'b1, 1'b0, 1'b0, 32'h0000_0200);
        fetch(32'h0000_FFFE);
        accept(1'b1, 1'b1, 1'b1, 32'h0000_1000);
        check_eq("prio_jr", imem_addr, 32'h0000_1000);

        // Jump beats branch: {0, 0xFFFE<<2}.
        fetch(32'h0);
        accept(1'b1, 1'b0, 1'b0, 32'h0000_0200);
        fetch(32'h0000_FFFE);
        accept(1'b0, 1'b1, 1'b1, 32'h0);
        check_eq("prio_j", imem_addr, 32'h0003_FFF8);

        // Backward branch: 0x204 - 8.
        fetch(32'h0);
        accept(1'b1, 1'b0, 1'b0, 32'h0000_0200);
        fetch(32'h0000_FFFE);
        accept(1'b0, 1'b0, 1'b1, 32'h0);
        check_eq("br_addr", imem_addr, 32'h0000_01FC);

        // Sequential wrap from the top of the address space.
        fetch(32'h0);
        accept(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
        fetch(32'h0);
        check_eq("wrap_pc4", pc_plus4, 32'h0);
        accept(1'b0, 1'b0, 1'b0, 32'h0);
        check_eq("wrap_addr", imem_addr, 32'h0);
        check_eq("wrap_retired", retired, exp_ret);

        // Misaligned register jump.
        fetch(32'h0);
        accept(1'b1, 1'b0, 1'b0, 32'h0000_1002);
`ifdef FETCH_ALIGN_CHECK_EN
        check_eq("al_fault", {31'd0, fetch_fault}, 32'd1);
        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("al_req", {31'd0, imem_req}, 32'd0);
            check_eq("al_valid", {31'd0, ins_valid}, 32'd0);
            check_eq("al_sticky", {31'd0, fetch_fault}, 32'd1);
        end
        imem_ready = 1'b0;
`else
        check_eq("al_addr", imem_addr, 32'h0000_1000);
        check_eq("al_fault", {31'd0, fetch_fault}, 32'd0);
        check_eq("al_req", {31'd0, imem_req}, 32'd1);
`endif

        // Reset mid-request with a ready in the same cycle.
        do_reset();
        check_eq("rr_start", imem_addr, 32'h0);
        check_eq("rr_fault", {31'd0, fetch_fault}, 32'd0);
        fetch(32'h0);
        accept(1'b1, 1'b0, 1'b0, 32'h0000_1000);
        check_eq("rr_req", {31'd0, imem_req}, 32'd1);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        reset = 1'b0;
        check_eq("rr_req0", {31'd0, imem_req}, 32'd0);
        check_eq("rr_ins", ins, 32'h0);
        check_eq("rr_valid", {31'd0, ins_valid}, 32'd0);
        check_eq("rr_pc", pc_out, 32'h0);
        check_eq("rr_retired", retired, 32'h0);
        step();
        imem_ready = 1'b0;
        check_eq("rr_late_valid", {31'd0, ins_valid}, 32'd0);
        check_eq("rr_late_req", {31'd0, imem_req}, 32'd1);
        check_eq("rr_late_ins", ins, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
